// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter.
//   REQ_LOG / REQ_HOST : requester ids (sensor logger, I2C host)
//   DATA_W_DEF / ADDR_W_DEF : default RAM geometry (128 x 32)
//   pend_t : read-in-flight record {valid, id}
package ram_arb_pkg;

  localparam logic REQ_LOG  = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 7;

  typedef struct packed {
    logic valid;
    logic id;
  } pend_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with its last-grant register.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   req0, req1   : requests
//   gnt0, gnt1   : combinational grants, at most one high, forced low in reset
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_gnt_q, last_gnt_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        // Tie goes to whoever did not win last time.
        if (last_gnt_q == REQ_HOST) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end

    last_gnt_d = last_gnt_q;
    if (gnt0) begin
      last_gnt_d = REQ_LOG;
    end else if (gnt1) begin
      last_gnt_d = REQ_HOST;
    end
  end

  // Reset to the host id so the logger wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= REQ_HOST;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Shares one single-port RAM (sync write, registered read) between two requesters.
// One access is granted per clock (round-robin); read data returns two cycles after
// the grant on the issuing requester's rvalid/rdata.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   req/we/addr/wdata{0,1}           : requester access channels
//   gnt{0,1}                         : combinational grant
//   rvalid{0,1}, rdata{0,1}          : read return (rdata holds between returns)
//   ram_we, ram_addr, ram_d, ram_q   : RAM interface
//   conflict_cnt                     : saturating count of cycles with both requests
// Optional macro RAM_ARB_STATS_EN enables conflict_cnt; otherwise it is tied to 0.
module ram_arbiter_2p
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_q,
  output logic [CNT_W-1:0]  conflict_cnt
);

  pend_t pend_q, pend_d;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .req1 (req1),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  // RAM mux; with no grant the address/data follow requester 0 (don't-care).
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = addr0;
    ram_d    = wdata0;
    if (gnt1) begin
      ram_we   = we1;
      ram_addr = addr1;
      ram_d    = wdata1;
    end else if (gnt0) begin
      ram_we   = we0;
    end
  end

  always_comb begin
    pend_d.valid = (gnt0 && !we0) || (gnt1 && !we1);
    pend_d.id    = gnt1 ? REQ_HOST : REQ_LOG;
  end

  // pend_q lines up with ram_q: the RAM output is valid in the cycle after the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      pend_q  <= pend_d;
      rvalid0 <= pend_q.valid && (pend_q.id == REQ_LOG);
      rvalid1 <= pend_q.valid && (pend_q.id == REQ_HOST);
      if (pend_q.valid && (pend_q.id == REQ_LOG)) begin
        rdata0 <= ram_q;
      end
      if (pend_q.valid && (pend_q.id == REQ_HOST)) begin
        rdata1 <= ram_q;
      end
    end
  end

`ifdef RAM_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (req0 && req1 && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Bench for ram_arbiter_2p: behavioural RAM, transaction-level reference model,
// directed scenarios plus a randomized run.
module tb_ram_arbiter_2p;

`ifdef RAM_ARB_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int VW = 108 + CNT_W;

  logic clk = 1'b0;
  logic rst;
  logic req0, we0, req1, we1;
  logic [6:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic ram_we;
  logic [6:0] ram_addr;
  logic [31:0] ram_d, ram_q;
  logic [CNT_W-1:0] conflict_cnt;

  always #5 clk = ~clk;

  ram_arbiter_2p #(.DATA_W(32), .ADDR_W(7), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q),
    .conflict_cnt(conflict_cnt)
  );

  // Single-port RAM: synchronous write, registered read.
  logic [31:0] mem [128];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_d;
    ram_q <= mem[ram_addr];
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic        id;
    logic [31:0] data;
  } ret_t;

  ret_t        ret_q[$];
  logic [31:0] m_mem [128];
  logic        m_last;
  logic        m_rv0, m_rv1, m_g0, m_g1;
  logic [31:0] m_rd0, m_rd1;
  int          m_cnt;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;

  task automatic model_reset();
    ret_q.delete();
    m_last = 1'b1;
    m_rv0 = 1'b0; m_rv1 = 1'b0; m_g0 = 1'b0; m_g1 = 1'b0;
    m_rd0 = '0; m_rd1 = '0;
    m_cnt = 0;
  endtask

  // [0]=grant 0, [1]=grant 1
  function automatic logic [1:0] exp_grant();
    if (req0 && req1) return (m_last == 1'b1) ? 2'b01 : 2'b10;
    return {req1, req0};
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt();
`ifdef RAM_ARB_STATS_EN
    return CNT_W'(m_cnt);
`else
    return '0;
`endif
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [1:0] g;
    logic ew;
    g  = exp_grant();
    ew = (g[0] && we0) || (g[1] && we1);
    return {g[0], g[1], m_rv0, m_rv1, m_rd0, m_rd1, ew,
            g[1] ? addr1 : addr0, g[1] ? wdata1 : wdata0, exp_cnt()};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_we, ram_addr, ram_d,
            conflict_cnt};
  endfunction

  // Advance the model by one accepted clock, then step past the edge.
  task automatic tick();
    logic [1:0] g;
    logic       id, w;
    logic [6:0] a;
    ret_t       r;
    g = exp_grant();
    m_g0 = g[0];
    m_g1 = g[1];
    id = g[1];
    w  = id ? we1 : we0;
    a  = id ? addr1 : addr0;
    if (g != 2'b00) begin
      m_last = id;
      if (w) m_mem[a] = id ? wdata1 : wdata0;
      else   ret_q.push_back('{due: cyc + 2, id: id, data: m_mem[a]});
    end
    if (req0 && req1 && m_cnt < CNT_MAX) m_cnt++;
    @(posedge clk);
    cyc++;
    #1;
    m_rv0 = 1'b0;
    m_rv1 = 1'b0;
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      r = ret_q.pop_front();
      if (r.id) begin m_rv1 = 1'b1; m_rd1 = r.data; end
      else      begin m_rv0 = 1'b1; m_rd0 = r.data; end
    end
  endtask

  task automatic set0(input logic r, input logic w, input logic [6:0] a, input logic [31:0] d);
    req0 = r; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic [6:0] a, input logic [31:0] d);
    req1 = r; we1 = w; addr1 = a; wdata1 = d;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    set0(1'b1, 1'b1, 7'h12, 32'h1234_5678);
    set1(1'b1, 1'b0, 7'h34, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    n_vec++;
    if ({gnt0, gnt1, rvalid0, rvalid1, ram_we, rdata0, rdata1, conflict_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_values got=%b%b%b%b%b %h %h %h want=all zero", gnt0, gnt1, rvalid0,
               rvalid1, ram_we, rdata0, rdata1, conflict_cnt);
    end
    model_reset();
    set0(1'b0, 1'b0, 7'h0, 32'h0);
    set1(1'b0, 1'b0, 7'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_preload();
    for (int k = 0; k < 128; k++) begin
      set0(1'b1, 1'b1, 7'(k), $urandom);
      @(negedge clk);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL preload cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    for (int k = 0; k < 6; k++) begin
      case (k)
        0:       set0(1'b1, 1'b1, 7'h05, 32'hDEAD_BEEF);
        1:       set0(1'b1, 1'b0, 7'h05, 32'h0);
        default: set0(1'b0, 1'b0, 7'h05, 32'h0);
      endcase
      @(negedge clk);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL write_read cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_alternate();
    for (int k = 0; k < 11; k++) begin
      case (k)
        0: set0(1'b1, 1'b1, 7'h10, 32'h1111_1111);
        1: begin set0(1'b0, 1'b0, 7'h10, 32'h0); set1(1'b1, 1'b1, 7'h20, 32'h2222_2222); end
        2: begin set0(1'b1, 1'b0, 7'h10, 32'h0); set1(1'b1, 1'b0, 7'h20, 32'h0); end
        8: begin set0(1'b0, 1'b0, 7'h10, 32'h0); set1(1'b0, 1'b0, 7'h20, 32'h0); end
        default: ;
      endcase
      @(negedge clk);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL alternate cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_interleave();
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: set0(1'b1, 1'b1, 7'h7F, 32'hCAFE_F00D);
        1: set0(1'b1, 1'b1, 7'h00, 32'h0);
        2: begin set0(1'b0, 1'b0, 7'h00, 32'h0); set1(1'b1, 1'b0, 7'h7F, 32'h0); end
        3: begin set0(1'b1, 1'b0, 7'h00, 32'h0); set1(1'b0, 1'b0, 7'h7F, 32'h0); end
        default: set0(1'b0, 1'b0, 7'h00, 32'h0);
      endcase
      @(negedge clk);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL interleave cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  // Fresh reset, then both write 0x7F: logger first, host second, host's data survives.
  task automatic test_tie_after_reset();
    rst = 1'b1;
    #2;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: begin set0(1'b1, 1'b1, 7'h7F, 32'hA5A5_A5A5); set1(1'b1, 1'b1, 7'h7F, 32'h5A5A_5A5A); end
        2: set0(1'b1, 1'b0, 7'h7F, 32'h0);
        default: ;
      endcase
      @(negedge clk);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL tie_after_reset cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      tick();
      if (m_g0) req0 = 1'b0;
      if (m_g1) req1 = 1'b0;
    end
  endtask

  task automatic test_reset_mid_read();
    set0(1'b1, 1'b0, 7'h05, 32'h0);
    @(negedge clk);
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL mid_read_issue cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
    end
    tick();
    set1(1'b1, 1'b0, 7'h20, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({gnt0, gnt1, rvalid0, rvalid1, ram_we, rdata0, rdata1, conflict_cnt} !== '0) begin
      n_fail++;
      $display("FAIL mid_read_reset got=%b%b%b%b%b %h %h %h want=all zero", gnt0, gnt1, rvalid0,
               rvalid1, ram_we, rdata0, rdata1, conflict_cnt);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    set0(1'b0, 1'b0, 7'h05, 32'h0);
    set1(1'b0, 1'b0, 7'h20, 32'h0);
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        set0(1'b1, 1'b0, 7'h10, 32'h0);
        set1(1'b1, 1'b0, 7'h20, 32'h0);
      end
      @(negedge clk);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL mid_read_after cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      tick();
      if (m_g0) req0 = 1'b0;
      if (m_g1) req1 = 1'b0;
    end
  endtask

  task automatic test_saturation();
    set0(1'b1, 1'b0, 7'h10, 32'h0);
    set1(1'b1, 1'b0, 7'h20, 32'h0);
    for (int k = 0; k < 23; k++) begin
      if (k == 20) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      @(negedge clk);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL saturation cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_random();
    m_g0 = 1'b0;
    m_g1 = 1'b0;
    for (int k = 0; k < 400; k++) begin
      // Hold an ungranted request (occasionally withdraw it), otherwise pick a fresh one.
      if (!(req0 && !m_g0 && $urandom_range(9) != 0)) begin
        set0($urandom_range(99) < 60, 1'($urandom), 7'($urandom), $urandom);
      end
      if (!(req1 && !m_g1 && $urandom_range(9) != 0)) begin
        set1($urandom_range(99) < 60, 1'($urandom), 7'($urandom), $urandom);
      end
      @(negedge clk);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      tick();
    end
    set0(1'b0, 1'b0, 7'h0, 32'h0);
    set1(1'b0, 1'b0, 7'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_drain cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    set0(1'b0, 1'b0, 7'h0, 32'h0);
    set1(1'b0, 1'b0, 7'h0, 32'h0);
    model_reset();
    test_reset();
    test_preload();
    test_write_read();
    test_alternate();
    test_interleave();
    test_tie_after_reset();
    test_reset_mid_read();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
